// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path.
//   state_t    : collector FSM encoding
//   PIX_W      : output pixel width
//   out_pixels : valid-convolution output pixel count per frame
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int PIX_W = 8;

  function automatic int out_pixels(input int img_length, input int kernel_size);
    return (img_length - kernel_size + 1) * (img_length - kernel_size + 1);
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, reset : clock, sync active-high reset
//   flush      : empties the FIFO (overrides push/pop)
//   push/din   : write when !full (or full with same-cycle pop)
//   pop        : advance head (caller guarantees !empty)
//   dout       : current head entry, valid while !empty
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full/empty are distinguishable.
module conv_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; empty gates anything read from it.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/conv_output_collector.sv
// Collects convolved samples, maps them to 8-bit pixels and buffers them
// for a valid/ready consumer. Tracks per-frame pixel count, tags the final
// pixel, flags dropped samples and reports frame completion.
//   clk, reset          : clock, sync active-high reset
//   frame_start         : arm for a new frame (flushes buffer, clears status)
//   in_valid, in_data   : convolved sample stream (two's complement)
//   out_valid/out_ready : pixel handshake; out_data/out_last describe the head
//   pixel_count         : samples accepted this frame
//   overflow            : sticky, a sample was dropped on a full buffer
//   frame_done          : all pixels captured and drained
// Build option: CONV_OUT_SATURATE_EN clamps signed samples to 0..255;
// without it the pixel is the low 8 bits of the sample.
module conv_output_collector
  import conv_pkg::*;
#(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_LENGTH  = 16,
  parameter int DEPTH       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_start,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            out_last,
  output logic [7:0]      pixel_count,
  output logic            overflow,
  output logic            frame_done
);

  localparam int OUT_PIXELS = out_pixels(IMG_LENGTH, KERNEL_SIZE);

  state_t state, state_nxt;

  logic             fifo_full, fifo_empty;
  logic [PIX_W:0]   fifo_din, fifo_dout;
  logic             accept, is_last, pop, push, drop;
  logic [PIX_W-1:0] pix;

  function automatic logic [PIX_W-1:0] map_pixel(input logic [BITS-1:0] d);
`ifdef CONV_OUT_SATURATE_EN
    if (d[BITS-1])                   return '0;
    else if (d > BITS'(255))         return '1;
    else                             return d[PIX_W-1:0];
`else
    return d[PIX_W-1:0];
`endif
  endfunction

`ifndef CONV_OUT_SATURATE_EN
  // Upper sample bits are discarded by truncation.
  logic unused_hi;
  assign unused_hi = ^in_data[BITS-1:PIX_W];
`endif

  // frame_start wins over a coincident sample.
  assign accept  = (state == COLLECT) && in_valid && !frame_start;
  assign is_last = (pixel_count == 8'(OUT_PIXELS - 1));
  assign pop     = out_valid && out_ready;
  // A full buffer can still take a sample if the head leaves this cycle.
  assign push    = accept && (!fifo_full || pop);
  assign drop    = accept && fifo_full && !pop;
  assign pix     = map_pixel(in_data);
  assign fifo_din = {is_last, pix};

  conv_out_fifo #(
    .WIDTH (PIX_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frame_start),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = out_valid ? fifo_dout[PIX_W-1:0] : '0;
  assign out_last   = out_valid & fifo_dout[PIX_W];
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && is_last) state_nxt = DRAIN;
        DRAIN:   if (fifo_empty)        state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Dropped samples still count so the frame boundary stays aligned.
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      pixel_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (accept) pixel_count <= pixel_count + 1'b1;
      if (drop)   overflow    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_output_collector.sv
module tb_conv_output_collector;

  localparam int NPIX = 196;
  localparam int QD   = 16;

  logic       clk = 0;
  logic       reset, frame_start, in_valid, out_ready;
  logic [8:0] in_data;
  logic       out_valid, out_last, overflow, frame_done;
  logic [7:0] out_data, pixel_count;

  conv_output_collector dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .pixel_count(pixel_count),
    .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {last, pixel}, frame phase, counters.
  typedef enum int {P_IDLE, P_COL, P_DRN, P_DONE} phase_t;
  logic [8:0] mq[$];
  phase_t     ph;
  int         cnt;
  bit         ovf;

  // Observed pops (from DUT) for directed checks.
  int         pops, lasts;
  logic [7:0] popped[$];

  function automatic logic [7:0] ref_pix(input logic [8:0] d);
`ifdef CONV_OUT_SATURATE_EN
    int v;
    v = $signed(d);
    if (v < 0)        return 8'h00;
    else if (v > 255) return 8'hFF;
    else              return d[7:0];
`else
    return d[7:0];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fs, input bit iv,
                      input logic [8:0] d, input bit rdy);
    phase_t ph0;
    int     n0;
    bit     dopop, store, lst;
    reset = rst; frame_start = fs; in_valid = iv; in_data = d; out_ready = rdy;
    if (!rst && out_valid && out_ready) begin
      pops++;
      if (out_last) lasts++;
      popped.push_back(out_data);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete(); ph = P_IDLE; cnt = 0; ovf = 0;
    end else if (fs) begin
      mq.delete(); ph = P_COL; cnt = 0; ovf = 0;
    end else begin
      ph0 = ph; n0 = mq.size(); dopop = (n0 > 0) && rdy;
      store = 0; lst = 0;
      if (ph0 == P_COL && iv) begin
        lst = (cnt == NPIX - 1);
        if (n0 < QD || dopop) store = 1;
        else ovf = 1;
        cnt++;
        if (lst) ph = P_DRN;
      end
      if (ph0 == P_DRN && n0 == 0) ph = P_DONE;
      if (dopop) void'(mq.pop_front());
      if (store) mq.push_back({lst, ref_pix(d)});
    end
    #1;
    chk("out_valid",   out_valid,   mq.size() > 0);
    chk("out_data",    out_data,    mq.size() > 0 ? mq[0][7:0] : 8'h00);
    chk("out_last",    out_last,    mq.size() > 0 ? mq[0][8] : 1'b0);
    chk("pixel_count", pixel_count, cnt);
    chk("overflow",    overflow,    ovf);
    chk("frame_done",  frame_done,  ph == P_DONE);
  endtask

  task automatic clr_pops();
    pops = 0; lasts = 0; popped.delete();
  endtask

  logic [7:0] exp_q[$];
  int         guard;

  initial begin
    reset = 1; frame_start = 0; in_valid = 0; in_data = '0; out_ready = 0;
    ph = P_IDLE; cnt = 0; ovf = 0; clr_pops();

    // 1. reset, then samples without frame_start are ignored
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_count", pixel_count, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 9'(i), 1);
    chk("idle_count", pixel_count, 0);

    // 2. full frame, constant data, consumer always ready
    step(0, 1, 0, 0, 1);
    clr_pops();
    for (int i = 0; i < NPIX; i++) step(0, 0, 1, 9'h004, 1);
    guard = 0;
    while (!frame_done && guard < 40) begin step(0, 0, 0, 0, 1); guard++; end
    chk("f2_done",  frame_done, 1);
    chk("f2_pops",  pops, NPIX);
    chk("f2_lasts", lasts, 1);
    chk("f2_ovf",   overflow, 0);
    chk("f2_data0", popped[0], 8'h04);
    chk("f2_dataN", popped[NPIX-1], 8'h04);

    // 3. overflow: 17 samples with no consumer
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 9'(i), 0);
    chk("f3_ovf",   overflow, 1);
    chk("f3_count", pixel_count, 17);
    clr_pops();
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1);
    chk("f3_pops", pops, 16);
    for (int i = 0; i < 16 && i < popped.size(); i++) chk("f3_order", popped[i], 8'(i));
    chk("f3_empty", out_valid, 0);

    // 4. simultaneous push+pop on a full buffer
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 9'(100 + i), 0);
    clr_pops();
    for (int i = 0; i < 8; i++) step(0, 0, 1, 9'(200 + i), 1);
    chk("f4_ovf",  overflow, 0);
    chk("f4_full", out_valid, 1);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(100 + i));
    for (int i = 0; i < 8; i++)  exp_q.push_back(8'(200 + i));
    chk("f4_pops", popped.size(), 24);
    for (int i = 0; i < 24 && i < popped.size(); i++) chk("f4_order", popped[i], exp_q[i]);

    // 5. pixel mapping
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 9'h1F0, 0);
    step(0, 0, 1, 9'h0FF, 0);
    step(0, 0, 1, 9'h07A, 0);
    clr_pops();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("f5_pops", popped.size(), 3);
    if (popped.size() == 3) begin
`ifdef CONV_OUT_SATURATE_EN
      chk("f5_neg", popped[0], 8'h00);
`else
      chk("f5_neg", popped[0], 8'hF0);
`endif
      chk("f5_ff", popped[1], 8'hFF);
      chk("f5_7a", popped[2], 8'h7A);
    end

    // 6. restart mid-frame, then a randomized complete frame
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 46; i++) step(0, 0, 1, 9'(i), 1);
    for (int i = 0; i < 4; i++)  step(0, 0, 1, 9'(i), 0);
    chk("f6_count50", pixel_count, 50);
    step(0, 1, 1, 9'h055, 1);
    chk("f6_flush", out_valid, 0);
    chk("f6_clear", pixel_count, 0);
    guard = 0;
    while (cnt < NPIX && guard < 3000) begin
      step(0, 0, ($urandom_range(0, 3) != 0), 9'($urandom_range(0, 511)),
           ($urandom_range(0, 9) < 7));
      guard++;
    end
    chk("f6_count", pixel_count, NPIX);
    guard = 0;
    while (!frame_done && guard < 60) begin step(0, 0, 0, 0, $urandom_range(0, 1)); guard++; end
    chk("f6_done", frame_done, 1);

    // reset while draining
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) step(0, 0, 1, 9'($urandom_range(0, 511)), 0);
    step(0, 0, 0, 0, 0);
    chk("f7_pre_valid", out_valid, 1);
    step(1, 0, 1, 9'h011, 1);
    chk("f7_valid", out_valid, 0);
    chk("f7_data",  out_data, 0);
    chk("f7_last",  out_last, 0);
    chk("f7_count", pixel_count, 0);
    chk("f7_ovf",   overflow, 0);
    chk("f7_done",  frame_done, 0);
    step(0, 0, 1, 9'h011, 1);
    chk("f7_idle", pixel_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
